// File: rtl/vm_pkg.sv
// Shared definitions for the multi-product vending machine.
//   - Coin codes, identical for the acceptor input (cin) and the change output.
//   - FSM state encoding. These values appear directly on current_state.
//   - coin_value()/coin_valid() helpers, which work in nickel units.
package vm_pkg;

  // Coin codes. A code's value in nickels equals the code itself for 1..5.
  localparam logic [2:0] ZERO        = 3'd0;
  localparam logic [2:0] NICKEL      = 3'd1;
  localparam logic [2:0] DIME        = 3'd2;
  localparam logic [2:0] NICKEL_DIME = 3'd3;
  localparam logic [2:0] DIME_DIME   = 3'd4;
  localparam logic [2:0] QUARTER     = 3'd5;

  // FSM states. These encodings are visible on current_state.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_CREDIT = 2'd1;
  localparam logic [1:0] ST_VEND   = 2'd2;
  localparam logic [1:0] ST_CHANGE = 2'd3;

  function automatic logic coin_valid(input logic [2:0] code);
    return (code >= NICKEL) && (code <= QUARTER);
  endfunction

  // Value in nickels. Codes 0, 6 and 7 are worth nothing.
  function automatic logic [2:0] coin_value(input logic [2:0] code);
    logic [2:0] v;
    case (code)
      NICKEL:      v = 3'd1;
      DIME:        v = 3'd2;
      NICKEL_DIME: v = 3'd3;
      DIME_DIME:   v = 3'd4;
      QUARTER:     v = 3'd5;
      default:     v = 3'd0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/vm_change_encoder.sv
// Greedy change coin picker (combinational).
//   credit : remaining credit in nickels
//   code   : largest coin code in {5,4,3,2,1} that does not exceed credit (0 if credit==0)
//   value  : nickel value of code
module vm_change_encoder
  import vm_pkg::*;
#(
  parameter int CREDIT_W = 5
) (
  input  logic [CREDIT_W-1:0] credit,
  output logic [2:0]          code,
  output logic [2:0]          value
);

  logic [31:0] cr32;
  assign cr32 = 32'(credit);

  always_comb begin
    code = ZERO;
    if      (cr32 >= 32'd5) code = QUARTER;
    else if (cr32 == 32'd4) code = DIME_DIME;
    else if (cr32 == 32'd3) code = NICKEL_DIME;
    else if (cr32 == 32'd2) code = DIME;
    else if (cr32 == 32'd1) code = NICKEL;
  end

  assign value = coin_value(code);

endmodule

// File: rtl/vending_machine_multi.sv
// Multi-product coin vending controller.
// The machine accumulates credit in nickels, vends one of NUM_PRODUCTS products
// at the per-product prices, and then pays back the remaining credit. Change is
// paid one coin code per cycle.
//   clk, reset    : rising-edge clock, asynchronous active-high reset
//   cin           : coin code from the acceptor (0 means none, 6 and 7 are invalid)
//   sel, buy      : product select and purchase request
//   cancel        : refund request
//   product       : one-cycle dispense strobe; product_id is valid with it
//   change        : change coin code for this cycle; change_valid qualifies it
//   credit        : current credit in nickels
//   current_state : IDLE=0, CREDIT=1, VEND=2, CHANGE=3
//   coin_reject   : one-cycle pulse, coin returned unaccepted
//   buy_denied    : one-cycle pulse, insufficient credit or bad select
// A reset during VEND or CHANGE aborts at once. Any change not yet paid is lost.
module vending_machine_multi
  import vm_pkg::*;
#(
  parameter int NUM_PRODUCTS = 4,
  parameter int SEL_W        = 2,
  parameter int CREDIT_W     = 5,
  parameter int CREDIT_MAX   = 20,
  parameter logic [NUM_PRODUCTS*CREDIT_W-1:0] PRICE_TABLE = {5'd3, 5'd4, 5'd2, 5'd5}
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [2:0]          cin,
  input  logic [SEL_W-1:0]    sel,
  input  logic                buy,
  input  logic                cancel,
  output logic                product,
  output logic [SEL_W-1:0]    product_id,
  output logic [2:0]          change,
  output logic                change_valid,
  output logic [CREDIT_W-1:0] credit,
  output logic [1:0]          current_state,
  output logic                coin_reject,
  output logic                buy_denied
);

  logic [1:0]          state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                product_d, rej_d, den_d;
  logic [SEL_W-1:0]    pid_d;

  // Unpack the price table. Product i sits at bits [i*CREDIT_W +: CREDIT_W].
  logic [CREDIT_W-1:0] price [NUM_PRODUCTS];
  for (genvar i = 0; i < NUM_PRODUCTS; i++) begin : g_price
    assign price[i] = PRICE_TABLE[i*CREDIT_W +: CREDIT_W];
  end

  // Look up the price by comparing sel with each index. This keeps the lookup
  // safe when sel can address entries past NUM_PRODUCTS.
  logic                sel_ok;
  logic [CREDIT_W-1:0] sel_price;
  always_comb begin
    sel_ok    = 1'b0;
    sel_price = '0;
    for (int i = 0; i < NUM_PRODUCTS; i++) begin
      if (sel == SEL_W'(i)) begin
        sel_ok    = 1'b1;
        sel_price = price[i];
      end
    end
  end

  // The extra top bit means a coin near the ceiling cannot wrap and look small.
  logic [CREDIT_W:0] coin_sum;
  assign coin_sum = {1'b0, credit_q} + (CREDIT_W+1)'(coin_value(cin));

  logic [2:0] enc_code, enc_value;
  vm_change_encoder #(.CREDIT_W(CREDIT_W)) u_enc (
    .credit (credit_q),
    .code   (enc_code),
    .value  (enc_value)
  );

  always_comb begin
    state_d   = state_q;
    credit_d  = credit_q;
    product_d = 1'b0;
    pid_d     = product_id;
    rej_d     = 1'b0;
    den_d     = 1'b0;
    case (state_q)
      ST_IDLE, ST_CREDIT: begin
        // When no transition applies, the state follows the credit.
        state_d = (credit_q != '0) ? ST_CREDIT : ST_IDLE;
        if (cancel) begin
          rej_d = (cin != ZERO);
          if (credit_q != '0) state_d = ST_CHANGE;
        end else if (buy) begin
          rej_d = (cin != ZERO);
          if (sel_ok && (credit_q >= sel_price)) begin
            state_d   = ST_VEND;
            credit_d  = credit_q - sel_price;
            product_d = 1'b1;
            pid_d     = sel;
          end else begin
            den_d = 1'b1;
          end
        end else if (cin != ZERO) begin
          if (coin_valid(cin) && (coin_sum <= (CREDIT_W+1)'(CREDIT_MAX))) begin
            credit_d = coin_sum[CREDIT_W-1:0];
            state_d  = ST_CREDIT;
          end else begin
            rej_d = 1'b1;
          end
        end
      end
      ST_VEND: begin
        rej_d   = (cin != ZERO);
        state_d = (credit_q != '0) ? ST_CHANGE : ST_IDLE;
      end
      default: begin  // ST_CHANGE
        rej_d    = (cin != ZERO);
        credit_d = credit_q - CREDIT_W'(enc_value);
        if (credit_d == '0) state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      credit_q    <= '0;
      product     <= 1'b0;
      product_id  <= '0;
      coin_reject <= 1'b0;
      buy_denied  <= 1'b0;
    end else begin
      state_q     <= state_d;
      credit_q    <= credit_d;
      product     <= product_d;
      product_id  <= pid_d;
      coin_reject <= rej_d;
      buy_denied  <= den_d;
    end
  end

  // change is decoded from registered state, so it drops as soon as reset is asserted.
  assign change_valid  = (state_q == ST_CHANGE);
  assign change        = change_valid ? enc_code : ZERO;
  assign credit        = credit_q;
  assign current_state = state_q;

endmodule

// File: tb/tb_vending_machine_multi.sv
module tb_vending_machine_multi;

  logic       clk, reset;
  logic [2:0] cin;
  logic [1:0] sel;
  logic       buy, cancel;
  logic       product;
  logic [1:0] product_id;
  logic [2:0] change;
  logic       change_valid;
  logic [4:0] credit;
  logic [1:0] current_state;
  logic       coin_reject, buy_denied;

  int checks = 0;
  int errors = 0;

  vending_machine_multi dut (
    .clk(clk), .reset(reset), .cin(cin), .sel(sel), .buy(buy), .cancel(cancel),
    .product(product), .product_id(product_id), .change(change),
    .change_valid(change_valid), .credit(credit), .current_state(current_state),
    .coin_reject(coin_reject), .buy_denied(buy_denied)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] cin;  logic [1:0] sel; logic buy; logic cancel;
    logic prod; logic [1:0] pid; logic [2:0] chg; logic cv;
    logic [4:0] cr; logic [1:0] st; logic rej; logic den;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [2:0] c, input logic [1:0] s, input logic b,
                              input logic x, input logic p, input logic [1:0] id,
                              input logic [2:0] ch, input logic [4:0] cr,
                              input logic [1:0] st, input logic rj, input logic dn);
    vec_t v;
    v.cin = c; v.sel = s; v.buy = b; v.cancel = x;
    v.prod = p; v.pid = id; v.chg = ch; v.cv = (ch != 3'd0);
    v.cr = cr; v.st = st; v.rej = rj; v.den = dn;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d got %0d want %0d", name, idx, act, exp);
    end
  endtask

  task automatic chk_all_zero(input int idx);
    chk("rst_product", idx, 32'(product), 0);
    chk("rst_pid", idx, 32'(product_id), 0);
    chk("rst_change", idx, 32'(change), 0);
    chk("rst_cv", idx, 32'(change_valid), 0);
    chk("rst_credit", idx, 32'(credit), 0);
    chk("rst_state", idx, 32'(current_state), 0);
    chk("rst_reject", idx, 32'(coin_reject), 0);
    chk("rst_denied", idx, 32'(buy_denied), 0);
  endtask

  task automatic drive(input logic [2:0] c, input logic [1:0] s, input logic b,
                       input logic x);
    cin = c; sel = s; buy = b; cancel = x;
  endtask

  initial begin
    // Columns:  cin sel buy can | prod pid chg credit st rej den
    vecs.push_back(mk(1, 0, 0, 0,  0, 0, 0,  1, 1, 0, 0));
    vecs.push_back(mk(5, 0, 0, 0,  0, 0, 0,  6, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0,  1, 0, 0,  1, 2, 0, 0));  // buy p0 (5)
    vecs.push_back(mk(0, 0, 0, 0,  0, 0, 1,  1, 3, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0));
    vecs.push_back(mk(2, 0, 0, 0,  0, 0, 0,  2, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0,  0, 0, 0,  2, 1, 0, 1));  // insufficient
    vecs.push_back(mk(0, 0, 0, 1,  0, 0, 2,  2, 3, 0, 0));  // cancel
    vecs.push_back(mk(0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0));
    vecs.push_back(mk(5, 0, 0, 0,  0, 0, 0,  5, 1, 0, 0));
    vecs.push_back(mk(5, 0, 0, 0,  0, 0, 0, 10, 1, 0, 0));
    vecs.push_back(mk(5, 0, 0, 0,  0, 0, 0, 15, 1, 0, 0));
    vecs.push_back(mk(5, 0, 0, 0,  0, 0, 0, 20, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0,  0, 0, 0, 20, 1, 1, 0));  // over ceiling
    vecs.push_back(mk(0, 3, 1, 0,  1, 3, 0, 17, 2, 0, 0));  // buy p3 (3)
    vecs.push_back(mk(0, 0, 0, 0,  0, 0, 5, 17, 3, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0,  0, 0, 5, 12, 3, 1, 0));  // coin/buy in CHANGE
    vecs.push_back(mk(0, 0, 0, 0,  0, 0, 5,  7, 3, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,  0, 0, 2,  2, 3, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0));
    vecs.push_back(mk(6, 0, 0, 0,  0, 0, 0,  0, 0, 1, 0));  // invalid codes
    vecs.push_back(mk(7, 0, 0, 0,  0, 0, 0,  0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1,  0, 0, 0,  0, 0, 0, 0));  // cancel, no credit
    vecs.push_back(mk(0, 2, 1, 0,  0, 0, 0,  0, 0, 0, 1));  // buy, no credit
    vecs.push_back(mk(2, 0, 0, 0,  0, 0, 0,  2, 1, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0,  1, 1, 0,  0, 2, 0, 0));  // exact price p1
    vecs.push_back(mk(0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0));  // VEND -> IDLE
    vecs.push_back(mk(5, 0, 0, 0,  0, 0, 0,  5, 1, 0, 0));
    vecs.push_back(mk(5, 0, 1, 1,  0, 0, 5,  5, 3, 1, 0));  // cancel wins
    vecs.push_back(mk(0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0));
    vecs.push_back(mk(5, 0, 0, 0,  0, 0, 0,  5, 1, 0, 0));
    vecs.push_back(mk(5, 0, 0, 0,  0, 0, 0, 10, 1, 0, 0));
    vecs.push_back(mk(5, 0, 0, 0,  0, 0, 0, 15, 1, 0, 0));
    vecs.push_back(mk(4, 0, 0, 0,  0, 0, 0, 19, 1, 0, 0));
    vecs.push_back(mk(2, 0, 0, 0,  0, 0, 0, 19, 1, 1, 0));  // 21 > max
    vecs.push_back(mk(1, 0, 0, 0,  0, 0, 0, 20, 1, 0, 0));  // exactly max
    vecs.push_back(mk(0, 0, 0, 1,  0, 0, 5, 20, 3, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1,  0, 0, 5, 15, 3, 0, 0));  // cancel ignored
    vecs.push_back(mk(0, 0, 0, 0,  0, 0, 5, 10, 3, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,  0, 0, 5,  5, 3, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0));

    reset = 1'b1;
    drive(0, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk_all_zero(-1);
    reset = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].cin, vecs[i].sel, vecs[i].buy, vecs[i].cancel);
      @(negedge clk);
      chk("product", i, 32'(product), 32'(vecs[i].prod));
      if (vecs[i].prod) chk("product_id", i, 32'(product_id), 32'(vecs[i].pid));
      chk("change", i, 32'(change), 32'(vecs[i].chg));
      chk("change_valid", i, 32'(change_valid), 32'(vecs[i].cv));
      chk("credit", i, 32'(credit), 32'(vecs[i].cr));
      chk("state", i, 32'(current_state), 32'(vecs[i].st));
      chk("coin_reject", i, 32'(coin_reject), 32'(vecs[i].rej));
      chk("buy_denied", i, 32'(buy_denied), 32'(vecs[i].den));
    end

    // Assert reset asynchronously in the middle of a refund of 9 nickels.
    drive(5, 0, 0, 0); @(negedge clk);
    drive(4, 0, 0, 0); @(negedge clk);
    chk("seq_credit9", 100, 32'(credit), 9);
    drive(0, 0, 0, 1); @(negedge clk);
    chk("seq_chg_state", 101, 32'(current_state), 3);
    chk("seq_chg_code", 101, 32'(change), 5);
    drive(0, 0, 0, 0);
    #2 reset = 1'b1;
    #1 chk_all_zero(102);
    @(negedge clk);
    chk_all_zero(103);
    reset = 1'b0;
    drive(1, 0, 0, 0); @(negedge clk);
    chk("post_rst_credit", 104, 32'(credit), 1);
    chk("post_rst_state", 104, 32'(current_state), 1);
    chk("post_rst_reject", 104, 32'(coin_reject), 0);
    drive(0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vending_machine_multi.md
Name: vending_machine_multi

Overview:
- Parametrised successor to the single-product coin vending FSM.
- Adds: credit accumulated in nickel units, N selectable products with per-product prices, credit ceiling with coin rejection, cancel/refund, and multi-cycle change dispensing of one coin code per cycle.
- Sits between the coin acceptor (3-bit coin codes) and the dispense/change actuators.

Parameters:
- NUM_PRODUCTS, 4, number of selectable products (>=1).
- SEL_W, 2, select width = max(1, clog2(NUM_PRODUCTS)).
- CREDIT_W, 5, credit register width in nickel units.
- CREDIT_MAX, 20, maximum held credit in nickels (100c); must be <= 2^CREDIT_W-1.
- PRICE_TABLE, {5'd3,5'd4,5'd2,5'd5}, packed NUM_PRODUCTS*CREDIT_W prices in nickels; product i at bits [i*CREDIT_W +: CREDIT_W], so product0=5 (25c); every price >=1.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- cin  in  3  coin code: 0 none, 1 nickel(1), 2 dime(2), 3 nickel+dime(3), 4 dime+dime(4), 5 quarter(5); 6 and 7 invalid.
- sel  in  SEL_W  product select, sampled with buy.
- buy  in  1  purchase request, level sampled each edge.
- cancel  in  1  refund request.
- product  out  1  one-cycle dispense strobe.
- product_id  out  SEL_W  product being dispensed, valid with product.
- change  out  3  change coin code for this cycle (same encoding as cin); 0 when idle.
- change_valid  out  1  change holds a coin this cycle.
- credit  out  CREDIT_W  current credit in nickels.
- current_state  out  2  IDLE=0, CREDIT=1, VEND=2, CHANGE=3.
- coin_reject  out  1  one-cycle pulse: coin returned unaccepted.
- buy_denied  out  1  one-cycle pulse: buy with insufficient credit or out-of-range sel.

Behaviour:
- Reset (async): state IDLE, credit=0, all outputs 0. Reset mid-vend or mid-change aborts immediately; undispensed change is lost (documented).
- All state, credit and pulse outputs are registered.
- change and change_valid are decoded from state and credit: in CHANGE, change = largest code in {5,4,3,2,1} <= credit.
- IDLE/CREDIT, per edge; priority cancel > buy > coin:
  - cancel, credit>0: go to CHANGE.
  - cancel, credit==0: stay IDLE.
  - Any nonzero cin in the same cycle as cancel or buy gets coin_reject.
  - buy, sel<NUM_PRODUCTS and credit>=price[sel]: go to VEND; credit -= price; latch product_id=sel.
  - buy, insufficient credit or sel>=NUM_PRODUCTS: buy_denied=1; state/credit unchanged.
  - Coin only, code 1-5: if credit+value <= CREDIT_MAX, add value and go to CREDIT; else coin_reject, credit unchanged.
  - Coin code 6 or 7: coin_reject, no credit change.
  - credit==0 holds IDLE; credit>0 holds CREDIT.
- VEND: exactly one cycle with product=1. Next edge goes to CHANGE if credit>0, else IDLE.
- Latency: buy sampled at edge k, product high k..k+1; first change coin k+1..k+2.
- CHANGE: each cycle change_valid=1. At each edge credit -= change value; go to IDLE when credit reaches 0.
  - Example: 7 nickels gives codes 5 then 2 (2 cycles).
- VEND/CHANGE: any nonzero cin gets coin_reject; buy and cancel are ignored (no pulses).
- Arithmetic: compare credit+value at CREDIT_W+1 bits so there is no wrap. Credit never exceeds CREDIT_MAX and never underflows.

Decomposition:
- Package vm_pkg holds:
  - coin code constants (ZERO, NICKEL, DIME, NICKEL_DIME, DIME_DIME, QUARTER);
  - state encoding;
  - function coin_value(code) returning nickels (0 for invalid);
  - function coin_valid(code).
- Sub-module vm_change_encoder: combinational, input remaining credit, outputs largest coin code and its value. It is reusable by any future changer.

Test Plan:
- Reset; cin=1 then 5; buy sel=0 -> credit 1 then 6; product=1 with id=0 for one cycle; credit=1; one CHANGE cycle with change=1; then IDLE, credit=0.
- cin=2, buy sel=0 (price 5) -> buy_denied pulse, credit stays 2; then cancel -> CHANGE with change=2 for one cycle, then IDLE.
- Insert four quarters (credit 20), then cin=1 -> coin_reject pulse, credit stays 20; buy sel=3 (price 3) -> product, then change codes 5,5,5,2 over 4 cycles.
- cin=6 and cin=7 in IDLE -> coin_reject each time, credit 0, state IDLE.
- Same-cycle buy+cancel+cin=5 with credit 5 -> cancel wins: CHANGE with code 5, coin_reject=1, no product.
- Assert reset during CHANGE with credit 9 -> all outputs 0 asynchronously and state IDLE; coin accepted normally after reset release.
